fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Stall  input  1  hold the current fetch-stage instruction; no PC advance.
REQ-005 SHALL have port PCSrcE  input  1  redirect request from execute (taken branch or jump).
REQ-006 SHALL have port PCTargetE  input  32  redirect target address.
REQ-007 SHALL have port imem_req  output  1  instruction memory read request.
REQ-008 SHALL have port imem_addr  output  32  instruction memory read address.
REQ-009 SHALL have port imem_rvalid  input  1  read data valid, one cycle, variable latency of 0..N cycles after request.
REQ-010 SHALL have port imem_rdata  input  32  read data, qualified by imem_rvalid.
REQ-011 SHALL have port InstrF  output  32  instruction to the IF/ID register; NOP (32'h0000_0013) when not valid.
REQ-012 SHALL have port PCPlus4F  output  32  address of InstrF plus 4; 0 when not valid.
REQ-013 SHALL have port PCF  output  32  address of the instruction currently fetched or held.
REQ-014 SHALL have port InstrValidF  output  1  InstrF holds a real fetched instruction.

Function
REQ-015 SHALL implement the states IDLE, WAIT, VALID and DISCARD, with at most one memory request outstanding.
REQ-016 In IDLE, the block SHALL go to WAIT on the next edge without any condition.
REQ-017 In WAIT, imem_req SHALL be 1 and imem_addr SHALL equal PCF, held stable until imem_rvalid.
REQ-018 In WAIT with imem_rvalid=1, the block SHALL register imem_rdata into InstrF, set InstrValidF=1 and go to VALID, so the instruction is visible one cycle after rvalid.
REQ-019 In VALID with Stall=1, InstrF, PCPlus4F, PCF and InstrValidF SHALL all hold.
REQ-020 In VALID with Stall=0, PCF SHALL become PCF+4, InstrF SHALL become NOP with InstrValidF=0, and the state SHALL go to WAIT.
REQ-021 PCPlus4F SHALL equal PCF+4 while InstrValidF=1.
REQ-022 PCSrcE=1 SHALL take priority over Stall and over every state.
REQ-023 On PCSrcE=1, the block SHALL load PCF from {PCTargetE[31:2],2'b00}, force InstrF to NOP, and clear InstrValidF.
REQ-024 On PCSrcE=1 in WAIT with imem_rvalid=0, the block SHALL go to DISCARD; otherwise it SHALL go to IDLE.
REQ-025 A response arriving on the same edge as the redirect SHALL be dropped.
REQ-026 In DISCARD, imem_req SHALL be 0; the next imem_rvalid SHALL be dropped and the state SHALL go to IDLE.
REQ-027 A PCSrcE=1 pulse during DISCARD SHALL update PCF and keep the state in DISCARD.
REQ-028 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000.
REQ-029 imem_rvalid arriving in IDLE or VALID SHALL be ignored.

Reset
REQ-030 While rst=1, the block SHALL hold state=IDLE, PCF=RESET_PC, InstrF=32'h0000_0013, PCPlus4F=0, InstrValidF=0 and imem_req=0.
REQ-031 Reset asserted mid-request SHALL abandon the outstanding request without a DISCARD.
REQ-032 The memory SHALL NOT return data for a request abandoned by reset.

Configuration
REQ-033 With macro FETCH_PERF_EN defined, the block SHALL add output FetchWaitCnt (32-bit).
REQ-034 FetchWaitCnt SHALL increment on every cycle spent in WAIT or DISCARD, saturate at 32'hFFFF_FFFF and be reset to 0.
REQ-035 Without FETCH_PERF_EN, neither the port nor the counter logic SHALL exist, and behaviour SHALL be otherwise identical.

Structure
REQ-036 The shared package riscv_pkg SHALL hold the constant NOP_INSTR = 32'h0000_0013 and the enum fetch_state_t (IDLE, WAIT, VALID, DISCARD).
REQ-037 The block SHALL be a single module; no sub-module is required.

Verification
REQ-038 Reset with RESET_PC=32'h100 and 0-cycle memory latency -> imem_addr=32'h100; InstrF=mem[0x100] with PCPlus4F=32'h104 one cycle after rvalid.
REQ-039 Stall=1 for 3 cycles in VALID -> InstrF, PCF and PCPlus4F unchanged, and no imem_req.
REQ-040 PCSrcE=1 with PCTargetE=32'h203 during WAIT with latency 3 -> state DISCARD, the late response dropped, then a fetch from 32'h200.
REQ-041 PCSrcE=1 on the same cycle as imem_rvalid -> data dropped, InstrF=NOP, and the next fetch from the target.
REQ-042 PCF=32'hFFFF_FFFC, VALID, Stall=0 -> the next imem_addr is 32'h0000_0000.
REQ-043 rst pulsed during WAIT -> all outputs return to reset values immediately (asynchronous), then the fetch restarts at RESET_PC; with FETCH_PERF_EN defined, FetchWaitCnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and the fetch-stage state type.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    VALID   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, stall hold, execute redirect.
// Optional FETCH_PERF_EN adds the FetchWaitCnt stall-cycle counter output.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] PCF,
  output logic        InstrValidF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FetchWaitCnt
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_valid;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_target;
  logic         w_pending;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = PCTargetE & ~32'd3;
  // A request is still in flight at the memory if we are waiting or discarding.
  assign w_pending  = (r_state == WAIT) || (r_state == DISCARD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (PCSrcE) begin
      r_pc    <= w_target;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_state <= (w_pending && !imem_rvalid) ? DISCARD : IDLE;
    end else begin
      case (r_state)
        IDLE: r_state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= VALID;
          end
        end
        VALID: begin
          if (!Stall) begin
            r_pc    <= w_pc_plus4;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_state <= WAIT;
          end
        end
        DISCARD: begin
          if (imem_rvalid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == WAIT);
  assign imem_addr   = r_pc;
  assign InstrF      = r_instr;
  assign PCF         = r_pc;
  assign InstrValidF = r_valid;
  assign PCPlus4F    = r_valid ? w_pc_plus4 : 32'd0;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_wait_cnt <= 32'd0;
    else if (w_pending) r_wait_cnt <= sat_inc(r_wait_cnt);
  end

  assign FetchWaitCnt = r_wait_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit against an architectural PC-stream model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] InstrF, PCPlus4F, PCF;
  logic        InstrValidF;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchWaitCnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .InstrF(InstrF), .PCPlus4F(PCPlus4F), .PCF(PCF),
    .InstrValidF(InstrValidF)
`ifdef FETCH_PERF_EN
    , .FetchWaitCnt(FetchWaitCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model state: architectural PC of the next instruction, memory in-flight request.
  logic [31:0] exp_pc = RST_PC;
  bit          holding = 0;
  bit          busy = 0;
  bit          live = 0;
  int          cnt = 0;
  logic [31:0] maddr = 32'd0;
  int          lat_mode = 0;
  bit          mon_en = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic model_reset();
    exp_pc = RST_PC; holding = 0; busy = 0; live = 0; cnt = 0;
  endtask

  // One clock: called just after a rising edge, returns just after the next.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit stall);
    bit dlv;
    dlv = 0;
    if (busy && imem_req) check("addr_stable", imem_addr, maddr);
    if (!busy && imem_req) begin
      check("req_addr", imem_addr, exp_pc);
      busy = 1; live = 1; maddr = imem_addr;
      cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end
    if (busy) begin
      if (cnt == 0) begin dlv = 1; busy = 0; end
      else cnt--;
    end
    imem_rvalid = dlv;
    imem_rdata  = dlv ? mem_word(maddr) : $urandom;
    Stall = stall; PCSrcE = redir; PCTargetE = tgt;
    if (redir) begin
      exp_pc = {tgt[31:2], 2'b00}; holding = 0; live = 0;
    end else if (holding && !stall) begin
      exp_pc = exp_pc + 32'd4; holding = 0;
    end
    if (dlv && live && !redir) begin
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      holding = 1; live = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_new_req(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      if (imem_req && !busy) return;
      cycle(0, 32'd0, 0);
    end
    timeout(name);
  endtask

  task automatic wait_holding(input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      if (holding) return;
      cycle(0, 32'd0, 0);
    end
    timeout(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_InstrF"}, InstrF, NOP);
    check({tag, "_PCF"}, PCF, RST_PC);
    check({tag, "_PCPlus4F"}, PCPlus4F, 32'd0);
    check({tag, "_valid"}, {31'd0, InstrValidF}, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
`ifdef FETCH_PERF_EN
    check({tag, "_waitcnt"}, FetchWaitCnt, 32'd0);
`endif
  endtask

  // Monitor: pops the scoreboard whenever a fresh instruction appears.
  logic [31:0] p_instr = 32'd0, p_pc = 32'd0, p_pc4 = 32'd0;
  logic        p_valid = 0, p_stall = 0, p_redir = 0;
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (p_valid && p_stall && !p_redir) begin
          check("hold_InstrF", InstrF, p_instr);
          check("hold_PCF", PCF, p_pc);
          check("hold_PCPlus4F", PCPlus4F, p_pc4);
          check("hold_req", {31'd0, imem_req}, 32'd0);
        end
        if (!InstrValidF) begin
          check("nop_when_invalid", InstrF, NOP);
          check("pc4_zero_when_invalid", PCPlus4F, 32'd0);
        end else if (!p_valid) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_instr: got pc %h expected no instruction", PCF);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc", PCF, e[63:32]);
            check("instr_data", InstrF, e[31:0]);
            check("instr_pc4", PCPlus4F, e[63:32] + 32'd4);
          end
        end
      end
      p_instr = InstrF; p_pc = PCF; p_pc4 = PCPlus4F;
      p_valid = InstrValidF; p_stall = Stall; p_redir = PCSrcE;
    end
  end

  initial begin
    logic [31:0] tgt;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 0;
    model_reset();
    mon_en = 1;

    // First fetch from RESET_PC with zero-latency memory.
    lat_mode = 0;
    wait_new_req("first_req");
    check("first_addr", imem_addr, RST_PC);
    wait_holding("first_instr");

    // Three stalled cycles while holding an instruction.
    repeat (3) cycle(0, 32'd0, 1);
    cycle(0, 32'd0, 0);

    // Redirect during WAIT with latency 3 -> late response dropped.
    lat_mode = 3;
    wait_new_req("redir_wait_req");
    cycle(0, 32'd0, 0);
    cycle(1, 32'h0000_0203, 0);
    check("discard_PCF", PCF, 32'h0000_0200);
    check("discard_req", {31'd0, imem_req}, 32'd0);
    check("discard_valid", {31'd0, InstrValidF}, 32'd0);
    wait_new_req("after_discard_req");
    check("after_discard_addr", imem_addr, 32'h0000_0200);
    wait_holding("after_discard_instr");

    // Redirect on the same cycle as the response.
    lat_mode = 0;
    cycle(0, 32'd0, 0);
    wait_new_req("same_cycle_req");
    cycle(1, 32'h0000_0300, 0);
    check("same_cycle_InstrF", InstrF, NOP);
    check("same_cycle_valid", {31'd0, InstrValidF}, 32'd0);
    wait_new_req("same_cycle_next_req");
    check("same_cycle_next_addr", imem_addr, 32'h0000_0300);

    // PC wraps at the top of the address space.
    lat_mode = 1;
    cycle(1, 32'hFFFF_FFFE, 0);
    wait_holding("wrap_instr");
    cycle(0, 32'd0, 0);
    wait_new_req("wrap_req");
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Randomized traffic.
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle($urandom_range(0, 99) < 6, tgt, $urandom_range(0, 99) < 30);
    end

    // Asynchronous reset in the middle of a request.
    lat_mode = 3;
    cycle(0, 32'd0, 0);
    wait_new_req("async_req");
    cycle(0, 32'd0, 0);
    mon_en = 0;
    #3 rst = 1;
    #1 check_reset_outputs("async_reset");
    imem_rvalid = 0; Stall = 0; PCSrcE = 0;
    @(posedge clk); #1;
    check_reset_outputs("async_hold");
    rst = 0;
    model_reset();
    exp_q.delete();
    mon_en = 1;
    wait_new_req("restart_req");
    check("restart_addr", imem_addr, RST_PC);
    wait_holding("restart_instr");
    repeat (3) cycle(0, 32'd0, 0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
